// File: rtl/aes_pkg.sv
// Shared AES datapath definitions: FSM state encoding and default word geometry
// for the sequential shifter.
package aes_pkg;

   localparam int DEF_WIDTH   = 32;
   localparam int DEF_SHAMT_W = 5;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

endpackage

// File: rtl/seq_shifter_step.sv
// One-bit shift/rotate stage: moves data one position left or right, filling
// the vacated bit with zero or, when rotating, with the bit shifted out.
module seq_shifter_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] data,
   input  logic             right,
   input  logic             rotate,
   output logic [WIDTH-1:0] result
);

   logic fill_left;
   logic fill_right;

   always_comb begin
      fill_left  = rotate & data[WIDTH-1];
      fill_right = rotate & data[0];
      if (right) begin
         result = {fill_right, data[WIDTH-1:1]};
      end else begin
         result = {data[WIDTH-2:0], fill_left};
      end
   end

endmodule

// File: rtl/seq_shifter.sv
// Multi-cycle shift engine, one bit position per clock between two valid/ready
// handshakes. Define SEQ_SHIFTER_ROTATE_EN to add the rotate input.
module seq_shifter
   import aes_pkg::*;
#(
   parameter int WIDTH   = DEF_WIDTH,
   parameter int SHAMT_W = DEF_SHAMT_W
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   in,
   input  logic [SHAMT_W-1:0] shift_amount,
   input  logic               right,
`ifdef SEQ_SHIFTER_ROTATE_EN
   input  logic               rotate,
`endif
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH-1:0]   out,
   output logic               busy
);

   state_t             state;
   state_t             state_nx;
   logic               accept;
   logic [WIDTH-1:0]   data_p0;
   logic [WIDTH-1:0]   step_data;
   logic [SHAMT_W-1:0] cnt;
   logic               dir;
   logic               rot;

   // Control: state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Next-state and handshake decode; unused encodings fall back to IDLE
   always_comb begin
      state_nx  = ST_IDLE;
      accept    = 1'b0;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      case (state)
         ST_IDLE: begin
            in_ready = 1'b1;
            accept   = in_valid;
            if (in_valid) begin
               state_nx = (shift_amount != '0) ? ST_SHIFT : ST_DONE;
            end else begin
               state_nx = ST_IDLE;
            end
         end
         ST_SHIFT: begin
            busy     = 1'b1;
            state_nx = (cnt == SHAMT_W'(1)) ? ST_DONE : ST_SHIFT;
         end
         ST_DONE: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            state_nx  = out_ready ? ST_IDLE : ST_DONE;
         end
         default: begin
            state_nx = ST_IDLE;
         end
      endcase
   end

   // Datapath: load at accept, one step per SHIFT cycle, hold otherwise
   always_ff @(posedge clk) begin
      if (rst) begin
         data_p0 <= '0;
         cnt     <= '0;
         dir     <= 1'b0;
      end else if (accept) begin
         data_p0 <= in;
         cnt     <= shift_amount;
         dir     <= right;
      end else if (state == ST_SHIFT) begin
         data_p0 <= step_data;
         cnt     <= cnt - SHAMT_W'(1);
      end
   end

`ifdef SEQ_SHIFTER_ROTATE_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         rot <= 1'b0;
      end else if (accept) begin
         rot <= rotate;
      end
   end
`else
   assign rot = 1'b0;
`endif

   seq_shifter_step #(
      .WIDTH (WIDTH)
   ) u_step (
      .data   (data_p0),
      .right  (dir),
      .rotate (rot),
      .result (step_data)
   );

   // out is the working register itself; it is only meaningful with out_valid
   assign out = data_p0;

endmodule

// File: tb/tb_seq_shifter.sv
// Scoreboard bench for seq_shifter: directed vectors plus randomized requests
// checked against an arithmetic shift/rotate model.
module tb_seq_shifter;

`ifdef SEQ_SHIFTER_ROTATE_EN
   localparam bit ROT_EN = 1'b1;
`else
   localparam bit ROT_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_d = '0;
   logic [4:0]  shift_amount = '0;
   logic        right = 1'b0;
   logic        rotate = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [31:0] out_d;
   logic        busy;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   typedef struct {
      logic [31:0] res;
      int          acc;
      int          n;
   } exp_t;

   exp_t q[$];

   always #5 clk = ~clk;

   seq_shifter dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in           (in_d),
      .shift_amount (shift_amount),
      .right        (right),
`ifdef SEQ_SHIFTER_ROTATE_EN
      .rotate       (rotate),
`endif
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out          (out_d),
      .busy         (busy)
   );

   function automatic logic [31:0] model(input logic [31:0] d, input int n,
                                         input bit r, input bit rot);
      logic [31:0] res;
      if (n == 0) res = d;
      else if (rot && !r) res = (d << n) | (d >> (32 - n));
      else if (rot && r) res = (d >> n) | (d << (32 - n));
      else if (r) res = d >> n;
      else res = d << n;
      return res;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic timeout(input string name);
      tests++;
      fails++;
      $display("FAIL %s: timed out waiting (cycle %0d)", name, cyc);
   endtask

   initial forever @(posedge clk) cyc++;

   // Monitor / scoreboard
   initial begin
      bit          rst_prev = 1'b0;
      bit          lat_done = 1'b0;
      bit          hold_vld = 1'b0;
      logic [31:0] hold_val = '0;
      forever begin
         @(negedge clk);
         if (rst_prev) begin
            check("reset in_ready", {31'b0, in_ready}, 32'd1);
            check("reset out_valid", {31'b0, out_valid}, 32'd0);
            check("reset out", out_d, 32'd0);
            check("reset busy", {31'b0, busy}, 32'd0);
         end
         if (rst) begin
            q.delete();
            lat_done = 1'b0;
            hold_vld = 1'b0;
         end else begin
            if (in_valid && in_ready) begin
               exp_t e;
               e.res = model(in_d, int'(shift_amount), right, rotate & ROT_EN);
               e.acc = cyc + 1;
               e.n   = int'(shift_amount);
               q.push_back(e);
            end
            if (out_valid) begin
               if (q.size() == 0) begin
                  check("spurious out_valid", {31'b0, out_valid}, 32'd0);
               end else begin
                  if (!lat_done) begin
                     check("latency", cyc - q[0].acc, q[0].n);
                     lat_done = 1'b1;
                  end
                  if (hold_vld) check("out stable under backpressure", out_d, hold_val);
                  check("in_ready low in DONE", {31'b0, in_ready}, 32'd0);
                  if (out_ready) begin
                     check("result", out_d, q[0].res);
                     void'(q.pop_front());
                     lat_done = 1'b0;
                     hold_vld = 1'b0;
                  end else begin
                     hold_vld = 1'b1;
                     hold_val = out_d;
                  end
               end
            end else begin
               hold_vld = 1'b0;
            end
         end
         rst_prev = rst;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [31:0] d, input int n, input bit r,
                       input bit rot, input bit noisy);
      int t = 0;
      while (!in_ready && t < 200) begin
         step();
         t++;
      end
      if (!in_ready) timeout("wait in_ready");
      in_valid     = 1'b1;
      in_d         = d;
      shift_amount = 5'(n);
      right        = r;
      rotate       = rot & ROT_EN;
      step();
      in_valid = 1'b0;
      if (noisy) begin
         t = 0;
         while (busy && !out_valid && t < 200) begin
            in_valid     = 1'($urandom);
            in_d         = $urandom;
            shift_amount = 5'($urandom);
            right        = 1'($urandom);
            rotate       = 1'($urandom) & ROT_EN;
            step();
            t++;
         end
         in_valid = 1'b0;
      end
   endtask

   task automatic wait_idle(input bit rand_ready);
      int t = 0;
      while ((q.size() != 0 || !in_ready) && t < 400) begin
         if (rand_ready) out_ready = 1'($urandom);
         step();
         t++;
      end
      out_ready = 1'b1;
      if (q.size() != 0 || !in_ready) timeout("wait idle");
   endtask

   initial begin
      #200_000;
      $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int t;
      step();
      step();
      rst = 1'b0;
      step();

      // Reset mid-operation, then a normal request
      send(32'hFFFF0000, 16, 1'b0, 1'b0, 1'b0);
      step();
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      step();
      check("post-reset idle", {30'b0, in_ready, out_valid}, 32'd2);
      send(32'hFFFF0000, 16, 1'b0, 1'b0, 1'b0);
      wait_idle(1'b0);

      // Left and right directed vectors
      send(32'h000000FF, 4, 1'b0, 1'b0, 1'b0);
      wait_idle(1'b0);
      send(32'h80000001, 31, 1'b1, 1'b0, 1'b0);
      wait_idle(1'b0);

      // Zero shift with 10 cycles of backpressure
      out_ready = 1'b0;
      send(32'hDEADBEEF, 0, 1'b0, 1'b0, 1'b0);
      t = 0;
      while (!out_valid && t < 50) begin
         step();
         t++;
      end
      if (!out_valid) timeout("wait out_valid");
      repeat (10) step();
      out_ready = 1'b1;
      step();
      check("idle after release", {30'b0, in_ready, out_valid}, 32'd2);
      wait_idle(1'b0);

      // Inputs toggled during SHIFT must not disturb the result
      send(32'hA5A5_0F0F, 12, 1'b1, 1'b0, 1'b1);
      wait_idle(1'b0);
      send(32'h1357_9BDF, 20, 1'b0, 1'b0, 1'b1);
      wait_idle(1'b0);

      // Rotate vectors (rotate forced to 0 in builds without the port)
      send(32'h12345678, 8, 1'b0, 1'b1, 1'b0);
      wait_idle(1'b0);
      send(32'h12345678, 8, 1'b0, 1'b0, 1'b0);
      wait_idle(1'b0);
      send(32'h12345678, 8, 1'b1, 1'b1, 1'b0);
      wait_idle(1'b0);

      // Randomized requests with random backpressure and input noise
      for (int i = 0; i < 60; i++) begin
         send($urandom, int'($urandom_range(0, 31)), 1'($urandom), 1'($urandom),
              1'($urandom));
         wait_idle(1'b1);
      end

      step();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
